// File: rtl/clock_stamp_if.sv
// Bus bundle for clock_stamp: time-base control, count outputs and per-channel capture handshake.
// The master side drives ticks, presets, events and acks; the slave side returns the count and stamps.
interface clock_stamp_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned N_CH  = 4
);
    logic                    t1us;
    logic                    load;
    logic [CNT_W-1:0]        load_val;
    logic [N_CH-1:0]         ev;
    logic [N_CH-1:0]         ack;
    logic [CNT_W-1:0]        usec;
    logic                    tick;
    logic                    wrap;
    logic [N_CH*CNT_W-1:0]   stamp;
    logic [N_CH-1:0]         stamp_vld;
    logic [N_CH-1:0]         stamp_ovf;

    modport master (
        output t1us, load, load_val, ev, ack,
        input  usec, tick, wrap, stamp, stamp_vld, stamp_ovf
    );

    modport slave (
        input  t1us, load, load_val, ev, ack,
        output usec, tick, wrap, stamp, stamp_vld, stamp_ovf
    );
endinterface

// File: rtl/clock_stamp.sv
// Microsecond time base with load preset and N_CH event timestamp channels.
// Async inputs are synchronised, rising edges drive the counter and per-channel capture.
module clock_stamp #(
    parameter int unsigned     CNT_W       = 32,
    parameter int unsigned     N_CH        = 4,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter longint unsigned MOD         = 0
) (
    input  logic        clk,
    input  logic        reset,
    clock_stamp_if.slave bus
);

    // Last legal count when a modulus is set; unused for natural wrap.
    localparam logic [CNT_W-1:0] ModLast = CNT_W'(MOD - 64'd1);

    logic [SYNC_STAGES-1:0] t_sync_q;
    logic                   t_dly_q;
    logic                   t_det;

    logic [SYNC_STAGES-1:0] ev_sync_q [N_CH];
    logic [N_CH-1:0]        ev_dly_q;
    logic [N_CH-1:0]        ev_det;

    logic [CNT_W-1:0]       usec_q;
    logic [CNT_W-1:0]       usec_d;
    logic [CNT_W-1:0]       usec_inc;
    logic                   wrap;

    logic [N_CH*CNT_W-1:0]  stamp_q;
    logic [N_CH-1:0]        vld_q;
    logic [N_CH-1:0]        ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_sync_q <= '0;
            t_dly_q  <= 1'b0;
            ev_dly_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ev_sync_q[i] <= '0;
            end
        end else begin
            t_sync_q <= {t_sync_q[SYNC_STAGES-2:0], bus.t1us};
            t_dly_q  <= t_sync_q[SYNC_STAGES-1];
            for (int i = 0; i < N_CH; i++) begin
                ev_sync_q[i] <= {ev_sync_q[i][SYNC_STAGES-2:0], bus.ev[i]};
                ev_dly_q[i]  <= ev_sync_q[i][SYNC_STAGES-1];
            end
        end
    end

    assign t_det = t_sync_q[SYNC_STAGES-1] & ~t_dly_q;

    always_comb begin
        ev_det = '0;
        for (int i = 0; i < N_CH; i++) begin
            ev_det[i] = ev_sync_q[i][SYNC_STAGES-1] & ~ev_dly_q[i];
        end
    end

    // Load wins over a coincident tick; out-of-range values fold to 0 on the next tick.
    always_comb begin
        if (MOD == 64'd0) begin
            usec_inc = usec_q + CNT_W'(1);
        end else begin
            usec_inc = (usec_q >= ModLast) ? '0 : usec_q + CNT_W'(1);
        end
        usec_d = usec_q;
        wrap   = 1'b0;
        if (bus.load) begin
            usec_d = bus.load_val;
        end else if (t_det) begin
            usec_d = usec_inc;
            wrap   = (usec_inc == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            usec_q <= '0;
        end else begin
            usec_q <= usec_d;
        end
    end

    // First event is kept until acked; ack in the event cycle makes room for the new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stamp_q <= '0;
            vld_q   <= '0;
            ovf_q   <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ev_det[i] && (!vld_q[i] || bus.ack[i])) begin
                    stamp_q[i*CNT_W +: CNT_W] <= usec_q;
                    vld_q[i]                  <= 1'b1;
                end else if (bus.ack[i]) begin
                    vld_q[i] <= 1'b0;
                end

                if (bus.ack[i]) begin
                    ovf_q[i] <= 1'b0;
                end else if (ev_det[i] && vld_q[i]) begin
                    ovf_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.usec      = usec_q;
    assign bus.tick      = t_det;
    assign bus.wrap      = wrap;
    assign bus.stamp     = stamp_q;
    assign bus.stamp_vld = vld_q;
    assign bus.stamp_ovf = ovf_q;

endmodule
